// File: rtl/transform_scheduler_if.sv
// Handshake and control bundle between the transform scheduler and its environment.
// The scheduler connects through the slave modport; a driver or testbench uses master.
interface transform_scheduler_if;
   logic       start;
   logic [5:0] qp_in;
   logic       in_valid;
   logic       in_ready;
   logic       pipe_enable;
   logic [3:0] qp_by_6;
   logic [2:0] qp_mod_6;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] blk_idx;
   logic       mb_done;
   logic       busy;

   modport master (
      output start, qp_in, in_valid, out_ready,
      input  in_ready, pipe_enable, qp_by_6, qp_mod_6, out_valid, blk_idx, mb_done, busy
   );

   modport slave (
      input  start, qp_in, in_valid, out_ready,
      output in_ready, pipe_enable, qp_by_6, qp_mod_6, out_valid, blk_idx, mb_done, busy
   );
endinterface

// File: rtl/transform_scheduler.sv
// Sequences one macroblock of 4x4 residual blocks through the transform/quant/invquant/invtran
// datapath, tracking in-flight blocks with a valid shift register and decoding QP for the quantisers.
module transform_scheduler #(
   parameter int PIPE_LAT      = 4,
   parameter int BLOCKS_PER_MB = 16
) (
   input logic                  clk,
   input logic                  reset,
   transform_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int            CW   = $clog2(BLOCKS_PER_MB + 1);
   localparam logic [CW-1:0] LAST = CW'(BLOCKS_PER_MB - 1);

   state_t              state;
   logic [PIPE_LAT-1:0] valid_sr;
   logic [CW-1:0]       in_cnt;
   logic [CW-1:0]       out_cnt;
   logic [3:0]          qp_by_6_q;
   logic [2:0]          qp_mod_6_q;
   logic                mb_done_q;

   logic                stall;
   logic                accept;
   logic                xfer;
   logic [5:0]          qp_clamped;

   // NOTE: in_ready and pipe_enable must react to out_ready in the same cycle, so they are
   // decoded combinationally from registered state rather than registered themselves.
   assign stall           = valid_sr[PIPE_LAT-1] & ~bus.out_ready;
   assign bus.in_ready    = (state == RUN) & ~stall;
   assign bus.pipe_enable = (state != IDLE) & ~stall;
   assign accept          = bus.in_valid & bus.in_ready;
   assign xfer            = valid_sr[PIPE_LAT-1] & bus.out_ready;
   assign qp_clamped      = (bus.qp_in > 6'd51) ? 6'd51 : bus.qp_in;

   assign bus.out_valid = valid_sr[PIPE_LAT-1];
   assign bus.blk_idx   = 4'(out_cnt);
   assign bus.qp_by_6   = qp_by_6_q;
   assign bus.qp_mod_6  = qp_mod_6_q;
   assign bus.mb_done   = mb_done_q;
   assign bus.busy      = (state != IDLE);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid_sr   <= '0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         qp_by_6_q  <= '0;
         qp_mod_6_q <= '0;
         mb_done_q  <= 1'b0;
      end else begin
         mb_done_q <= 1'b0;

         if (bus.pipe_enable)
            valid_sr <= (valid_sr << 1) | PIPE_LAT'(accept);

         case (state)
            IDLE: begin
               if (bus.start) begin
                  qp_by_6_q  <= 4'(qp_clamped / 6'd6);
                  qp_mod_6_q <= 3'(qp_clamped % 6'd6);
                  state      <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  in_cnt <= in_cnt + CW'(1);
                  if (in_cnt == LAST)
                     state <= DRAIN;
               end
            end
            default: ;
         endcase

         // The final output transfer closes the macroblock and overrides the case above.
         if (xfer) begin
            if (out_cnt == LAST) begin
               state     <= IDLE;
               mb_done_q <= 1'b1;
               in_cnt    <= '0;
               out_cnt   <= '0;
            end else begin
               out_cnt <= out_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: doc/transform_scheduler.md
TRANSFORM_SCHEDULER -- requirements
Module: transform_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 The block SHALL have parameter PIPE_LAT, default 4: cycles from block acceptance into the transform/quant/invquant/invtran datapath to the block appearing at its output.
REQ-003 The block SHALL have parameter BLOCKS_PER_MB, default 16: number of 4x4 blocks per macroblock.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
  - clk  in  1  clock; all state updates on its rising edge.
  - reset  in  1  async active-low reset.
  - start  in  1  begin a macroblock; sampled only in IDLE.
  - qp_in  in  6  macroblock QP; sampled with start.
  - in_valid  in  1  residual block offered to the datapath.
  - in_ready  out  1  block accepted when in_valid and in_ready are both 1.
  - pipe_enable  out  1  enable driven to all four datapath stages.
  - qp_by_6  out  4  floor(QP/6) for the quant and invquant stages.
  - qp_mod_6  out  3  QP mod 6 for the quant and invquant stages.
  - out_valid  out  1  reconstructed block valid at the datapath output.
  - out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both 1.
  - blk_idx  out  4  index (0..BLOCKS_PER_MB-1) of the block at the output.
  - mb_done  out  1  one-cycle pulse when the macroblock is complete.
  - busy  out  1  1 in any state other than IDLE.

Function
REQ-005 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-006 IDLE SHALL behave as follows:
  - in_ready=0 and pipe_enable=0.
  - When start=1, the block latches min(qp_in,51), registers qp_by_6 and qp_mod_6 at the same edge, and moves to RUN.
  - in_valid is ignored.
REQ-007 QP decomposition SHALL hold for all values 0..51, so that qp_by_6*6+qp_mod_6 equals the clamped QP. qp_in values 52..63 SHALL map to 8/3.
REQ-008 qp_by_6 and qp_mod_6 SHALL remain constant from the cycle after start until the next accepted start.
REQ-009 The stall signal SHALL be defined as stall = out_valid AND NOT out_ready; pipe_enable SHALL be NOT stall in RUN and DRAIN.
REQ-010 in_ready SHALL be 1 only in RUN with stall=0.
REQ-011 The block SHALL keep a PIPE_LAT-bit valid shift register.
  - When pipe_enable=1, the register shifts in (in_valid AND in_ready).
  - When pipe_enable=0, the register holds.
  - out_valid equals the last stage.
REQ-012 A block accepted in cycle t with no stalls SHALL present out_valid in cycle t+PIPE_LAT; each stall cycle adds exactly one cycle.
REQ-013 in_cnt SHALL count input handshakes; on reaching BLOCKS_PER_MB, the block moves RUN->DRAIN and in_ready=0.
REQ-014 out_cnt SHALL count output transfers, and blk_idx SHALL equal out_cnt.
REQ-015 When the transfer that makes out_cnt equal BLOCKS_PER_MB occurs, the block SHALL do all of the following:
  - move to IDLE;
  - pulse mb_done for exactly the following cycle;
  - clear in_cnt, out_cnt and blk_idx to 0.
REQ-016 start SHALL be ignored in RUN and DRAIN; the latched QP is unaffected.
REQ-017 Gaps in in_valid SHALL create bubbles (shift-register zeros); only handshakes count.
REQ-018 out_valid, blk_idx and the shift register SHALL hold unchanged while stalled.
REQ-019 The counters SHALL never exceed BLOCKS_PER_MB.

Reset
REQ-020 While reset=0, the block SHALL immediately (asynchronously) enter IDLE and force all of the following to 0:
  - in_ready, pipe_enable, out_valid, mb_done and busy;
  - qp_by_6, qp_mod_6 and blk_idx;
  - the shift register, in_cnt and out_cnt.
REQ-021 Reset asserted mid-RUN or mid-DRAIN SHALL discard all in-flight blocks, with no mb_done emitted.
REQ-022 The first start after reset release SHALL be honoured from the first rising edge with reset=1.

Verification
REQ-023 QP decode: the bench SHALL cover each of the following.
  - start with qp_in=28 -> next cycle qp_by_6=4, qp_mod_6=4, busy=1.
  - qp_in=51 -> 8/3.
  - qp_in=60 -> 8/3.
  - qp_in=0 -> 0/0.
REQ-024 Streaming: 16 back-to-back blocks, handshakes in cycles t..t+15, out_ready=1 -> the bench SHALL check all of the following.
  - out_valid in cycles t+4..t+19;
  - blk_idx 0..15;
  - mb_done=1 only in cycle t+20;
  - state IDLE from t+20.
REQ-025 Backpressure: out_ready=0 for 3 cycles while out_valid=1 with blk_idx=5 -> the bench SHALL check all of the following for those 3 cycles.
  - pipe_enable=0 and in_ready=0;
  - out_valid=1 and blk_idx=5;
  - the remaining blocks arrive 3 cycles later.
REQ-026 Bubbles: in_valid alternates 1/0 for 16 handshakes -> the bench SHALL check the following.
  - out_valid follows the same 1/0 pattern PIPE_LAT cycles later.
  - mb_done fires once.
REQ-027 Ignored inputs: the bench SHALL cover each of the following.
  - start with qp_in=40 during RUN -> qp_by_6/qp_mod_6 unchanged.
  - in_valid=1 in IDLE -> in_ready=0 and no out_valid.
REQ-028 Reset mid-operation: reset=0 during DRAIN with 2 blocks in flight -> the bench SHALL check all of the following.
  - all outputs read 0 the same cycle;
  - no out_valid or mb_done after release;
  - a new start works normally.
